// File: rtl/opl_timer_ctrl.sv
// OPL-style dual timer block: shared prescaler, two 8-bit up-counting timers
// with presets, per-timer masks, overflow flags and an active-low interrupt.
module opl_timer_ctrl #(
    parameter int TICK_CYCLES = 16384,
    parameter int T2_DIV      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] status,
    output logic       irq_n
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = (T2_DIV > 1) ? $clog2(T2_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(T2_DIV - 1);

    logic [PW-1:0] presc;
    logic [SW-1:0] sub2;
    logic [7:0]    preset1, preset2, cnt1, cnt2;
    logic          st1, st2, mask1, mask2, ft1, ft2;
    logic          tick, ctrl_wr, irq_rst, ctrl_load;
    logic          start1, start2, run1, run2, step2, ovf1, ovf2;
    logic          unused_bits;

    assign tick      = (presc == PRESC_LAST);
    assign ctrl_wr   = wr && (addr == 8'h04);
    assign irq_rst   = ctrl_wr && din[7];
    assign ctrl_load = ctrl_wr && !din[7];

    // A control write that clears a start bit stops the timer at that very edge.
    assign start1 = ctrl_load && din[0] && !st1;
    assign start2 = ctrl_load && din[1] && !st2;
    assign run1   = st1 && !(ctrl_load && !din[0]);
    assign run2   = st2 && !(ctrl_load && !din[1]);
    assign step2  = run2 && tick && (sub2 == SUB_LAST);
    assign ovf1   = run1 && tick && (cnt1 == 8'hFF);
    assign ovf2   = step2 && (cnt2 == 8'hFF);

    assign unused_bits = ^din[4:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset1 <= 8'h00;
            preset2 <= 8'h00;
            st1     <= 1'b0;
            st2     <= 1'b0;
            mask1   <= 1'b0;
            mask2   <= 1'b0;
        end else if (wr) begin
            if (addr == 8'h02) preset1 <= din;
            if (addr == 8'h03) preset2 <= din;
            if (ctrl_load) begin
                mask1 <= din[6];
                mask2 <= din[5];
                st2   <= din[1];
                st1   <= din[0];
            end
        end
    end

    // Start edge loads the preset and swallows any coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 8'h00;
        end else if (start1 || ovf1) begin
            cnt1 <= preset1;
        end else if (run1 && tick) begin
            cnt1 <= cnt1 + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt2 <= 8'h00;
            sub2 <= '0;
        end else if (start2) begin
            cnt2 <= preset2;
            sub2 <= '0;
        end else if (run2 && tick) begin
            if (step2) begin
                sub2 <= '0;
                cnt2 <= ovf2 ? preset2 : cnt2 + 8'd1;
            end else begin
                sub2 <= sub2 + 1'b1;
            end
        end
    end

    // A new overflow takes priority over a same-cycle IRQ reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ft1 <= 1'b0;
            ft2 <= 1'b0;
        end else begin
            if (ovf1 && !mask1)  ft1 <= 1'b1;
            else if (irq_rst)    ft1 <= 1'b0;
            if (ovf2 && !mask2)  ft2 <= 1'b1;
            else if (irq_rst)    ft2 <= 1'b0;
        end
    end

    assign status = {ft1 | ft2, ft1, ft2, 5'b00000};
    assign irq_n  = ~(ft1 | ft2);

endmodule

// File: tb/tb_opl_timer_ctrl.sv
// Directed self-checking bench for opl_timer_ctrl with a 4-cycle tick and
// timer-2 divide of 4; a local prescaler model locates tick edges.
module tb_opl_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] status;
    logic       irq_n;
    logic [1:0] m_presc;
    int         checks = 0;
    int         errors = 0;

    opl_timer_ctrl #(.TICK_CYCLES(4), .T2_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (wr),
        .addr   (addr),
        .din    (din),
        .status (status),
        .irq_n  (irq_n)
    );

    always #5 clk = ~clk;

    // After an edge, m_presc==0 means that edge carried a tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_presc <= 2'd0;
        else        m_presc <= m_presc + 2'd1;
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic checkStatus(input string tag, input logic [7:0] exp_status);
        checkOutput({tag, " status"}, status, exp_status);
        checkOutput({tag, " irq_n"}, {7'b0, irq_n}, {7'b0, ~exp_status[7]});
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        wr   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        wr   = 1'b0;
        addr = 8'h00;
        din  = 8'h00;
    endtask

    task automatic waitTicks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            #1;
            if (m_presc == 2'd0) k++;
        end
    endtask

    initial begin
        // Reset with writes that must be ignored
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h02, 8'hFE);
        applyStimulus(8'h04, 8'h01);
        checkStatus("in_reset", 8'h00);
        rst_n = 1'b1;
        waitTicks(3);
        checkStatus("writes_ignored_in_reset", 8'h00);

        // Timer 1, preset FE: overflow every 2 ticks
        applyStimulus(8'h02, 8'hFE);
        applyStimulus(8'h04, 8'h01);
        waitTicks(1);
        checkStatus("t1_tick1", 8'h00);
        waitTicks(1);
        checkStatus("t1_tick2", 8'hC0);
        applyStimulus(8'h04, 8'h80);
        checkStatus("t1_irq_reset", 8'h00);
        waitTicks(1);
        checkStatus("t1_tick3", 8'h00);
        waitTicks(1);
        checkStatus("t1_tick4", 8'hC0);
        applyStimulus(8'h04, 8'h00);
        checkStatus("t1_stop_keeps_flag", 8'hC0);
        applyStimulus(8'h04, 8'h80);
        checkStatus("t1_cleared", 8'h00);

        // Timer 2, preset FF: overflow after exactly T2_DIV ticks
        applyStimulus(8'h03, 8'hFF);
        applyStimulus(8'h04, 8'h02);
        for (int i = 1; i <= 3; i++) begin
            waitTicks(1);
            checkStatus($sformatf("t2_tick%0d", i), 8'h00);
        end
        waitTicks(1);
        checkStatus("t2_tick4", 8'hA0);
        applyStimulus(8'h04, 8'h00);
        applyStimulus(8'h04, 8'h80);
        checkStatus("t2_cleared", 8'h00);

        // Masked timer 1 keeps reloading without raising a flag
        applyStimulus(8'h02, 8'hFF);
        applyStimulus(8'h04, 8'h41);
        for (int i = 1; i <= 10; i++) begin
            waitTicks(1);
            checkStatus($sformatf("masked_tick%0d", i), 8'h00);
        end
        applyStimulus(8'h04, 8'h00);

        // IRQ reset landing on an overflow edge: set wins
        applyStimulus(8'h04, 8'h01);
        while (m_presc != 2'd3) begin
            @(posedge clk);
            #1;
        end
        checkStatus("before_collision", 8'h00);
        applyStimulus(8'h04, 8'h80);
        checkStatus("set_wins", 8'hC0);
        applyStimulus(8'h04, 8'h40);
        checkStatus("mask_after_set", 8'hC0);
        applyStimulus(8'h04, 8'h80);
        checkStatus("cleared_after_mask", 8'h00);
        applyStimulus(8'h04, 8'h00);

        // Reset mid-count abandons the timer and clears presets
        applyStimulus(8'h02, 8'hFE);
        applyStimulus(8'h04, 8'h01);
        waitTicks(2);
        checkStatus("pre_reset_flag", 8'hC0);
        #2;
        rst_n = 1'b0;
        #1;
        checkStatus("async_reset", 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitTicks(6);
        checkStatus("stopped_after_reset", 8'h00);
        applyStimulus(8'h04, 8'h01);
        waitTicks(255);
        checkStatus("preset_zero_tick255", 8'h00);
        waitTicks(1);
        checkStatus("preset_zero_tick256", 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
